flash_read_arbiter: RTL and testbench
=====================================

// Module: flash_read_arbiter
// PURPOSE
//  Shares the single-port weight/bias flash between two read requesters:
//  port 0 = network controller, port 1 = SPI readback/debug.
//  Issues one flash read at a time with a single-cycle strobe and waits the fixed flash latency.
//  Captures the returned word and returns it to the owning requester with a one-cycle valid pulse.
//  Arbitration is round-robin. Only one transaction is ever outstanding.
// PARAMETERS
//  ADDR_W      16  flash address width
//  DATA_W      16  flash data width
//  RD_LATENCY  11  cycles from flash_ready strobe to valid flash_data_in; legal range >=1
// PORTS
//  clk             in   1       system clock, all logic on rising edge
//  rst             in   1       asynchronous, active-high reset
//  req0            in   1       port 0 read request (level)
//  addr0           in   ADDR_W  port 0 read address, stable while req0=1
//  gnt0            out  1       port 0 grant pulse (request accepted)
//  rvalid0         out  1       port 0 read-data-valid pulse
//  req1            in   1       port 1 read request (level)
//  addr1           in   ADDR_W  port 1 read address, stable while req1=1
//  gnt1            out  1       port 1 grant pulse
//  rvalid1         out  1       port 1 read-data-valid pulse
//  rdata           out  DATA_W  last captured flash word (shared by both ports)
//  busy            out  1       1 whenever state != IDLE
//  flash_ready     out  1       one-cycle flash read strobe
//  flash_address   out  ADDR_W  flash read address
//  flash_data_in   in   DATA_W  flash read data, valid RD_LATENCY cycles after strobe
// BEHAVIOUR
//  Reset: state=IDLE; last_owner=1, so port 0 wins the first contention.
//   All outputs go to 0; any in-flight read is discarded; no rvalid follows.
//  FSM states: IDLE, ISSUE, WAIT, DONE. Every state, owner, address, count and rdata value is registered.
//  IDLE:
//   - Only one req high: latch that owner and its addr; go to ISSUE.
//   - Both high: grant the port != last_owner.
//   - No req: stay in IDLE.
//  ISSUE, 1 cycle:
//   - flash_ready=1; gnt<owner>=1; flash_address=latched addr.
//   - Set cnt=1 and last_owner=owner; go to WAIT.
//  WAIT:
//   - cnt increments each cycle.
//   - When cnt==RD_LATENCY: rdata<=flash_data_in on that edge; go to DONE.
//  DONE, 1 cycle: rvalid<owner>=1 with rdata stable; go to IDLE.
//  Timing:
//   - Strobe at cycle T, rdata is updated at the end of cycle T+RD_LATENCY.
//   - rvalid is high in cycle T+RD_LATENCY+1.
//   - Request-to-strobe latency is 1 cycle; issue-to-issue minimum is RD_LATENCY+3 cycles.
//  Address and data holding:
//   - flash_address holds the latched addr from ISSUE through DONE.
//   - Outside ISSUE..DONE it holds its last value.
//   - rdata holds until the next capture.
//  Counter: cnt is $clog2(RD_LATENCY+1) bits wide; it never wraps in normal operation.
//  Request rules:
//   - A req dropped before grant is ignored; no grant is given.
//   - Once the FSM has left IDLE, the transaction completes regardless of req and addr.
//   - A req still high after its own DONE counts as a new request.
//   - Round-robin then serves the other port if that port is pending.
//  Each gnt and rvalid is exactly 1 cycle wide; gnt0/gnt1 and rvalid0/rvalid1 are never high together.
//  Reset asserted mid-WAIT: immediate return to IDLE; no rvalid; next transaction starts clean.
// TESTING
//  1) req0=1, addr0=0x0010; flash model returns 0xBEEF 11 cycles after strobe ->
//     gnt0 and flash_ready high the cycle after req0 is seen, flash_address=0x0010;
//     rdata=0xBEEF and rvalid0 high 12 cycles after the strobe.
//  2) req0 and req1 raised in the same cycle after reset, addr0=0x0001, addr1=0x0100, both held ->
//     port 0 served first, then port 1.
//     Strobes are 14 cycles apart; rvalid0 then rvalid1 each return correct data.
//  3) req0 held high continuously, req1 pulsed high during port 0's WAIT and held ->
//     service order is 0,1,0,1; no port is granted twice while the other is pending.
//  4) req1 raised for 1 cycle while busy, then dropped before returning to IDLE ->
//     no gnt1, no strobe, busy=0 after the current DONE.
//  5) rst asserted at cnt=5 during a port 1 read, then released ->
//     all outputs 0 immediately; no rvalid1 ever appears; a following req0 is served normally.
//  6) RD_LATENCY=1 build, single req0 ->
//     strobe in cycle T, rdata captured at the end of T+1, rvalid0 high in T+2.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one single-port flash between two read requesters.
// Port 0 is the network controller and port 1 is SPI readback/debug.
// Only one read is outstanding at a time, and it always completes once issued.
module flash_read_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_LATENCY = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              flash_ready,
   output logic [ADDR_W-1:0] flash_address,
   input  logic [DATA_W-1:0] flash_data_in
);

   localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state;
   logic             owner;
   logic             last_owner;
   logic [CNT_W-1:0] cnt;
   logic             pick_c;

   // Port chosen from IDLE: the lone requester, or the port not served last on contention
   always_comb begin
      pick_c = req1;
      if (req0 && req1) begin
         pick_c = ~last_owner;
      end
   end

   // Transaction FSM; every output is registered and set on entry to the state that owns it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_owner    <= 1'b1;
         cnt           <= '0;
         gnt0          <= 1'b0;
         gnt1          <= 1'b0;
         rvalid0       <= 1'b0;
         rvalid1       <= 1'b0;
         rdata         <= '0;
         busy          <= 1'b0;
         flash_ready   <= 1'b0;
         flash_address <= '0;
      end else begin
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         flash_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner         <= pick_c;
                  flash_address <= pick_c ? addr1 : addr0;
                  gnt0          <= ~pick_c;
                  gnt1          <= pick_c;
                  flash_ready   <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               cnt        <= CNT_W'(1);
               last_owner <= owner;
               state      <= WAIT;
            end
            WAIT: begin
               if (cnt == CNT_W'(RD_LATENCY)) begin
                  rdata   <= flash_data_in;
                  rvalid0 <= ~owner;
                  rvalid1 <= owner;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: default latency instance plus a RD_LATENCY=1 instance.
// The flash model returns (addr ^ 0xBEFF) exactly RD_LATENCY cycles after a strobe, 0xDEAD otherwise.
module tb_flash_read_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned LAT_A = 11;
   localparam int unsigned LAT_B = 1;

   logic          clk;
   logic          rst;

   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic          gnt0, gnt1, rvalid0, rvalid1, busy, flash_ready;
   logic [DW-1:0] rdata, flash_data_in;
   logic [AW-1:0] flash_address;

   logic          req0_b, req1_b;
   logic [AW-1:0] addr0_b, addr1_b;
   logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b, flash_ready_b;
   logic [DW-1:0] rdata_b, flash_data_in_b;
   logic [AW-1:0] flash_address_b;

   int checks = 0;
   int errors = 0;

   flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_A)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy), .flash_ready(flash_ready),
      .flash_address(flash_address), .flash_data_in(flash_data_in)
   );

   flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst(rst),
      .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
      .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
      .rdata(rdata_b), .busy(busy_b), .flash_ready(flash_ready_b),
      .flash_address(flash_address_b), .flash_data_in(flash_data_in_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flash latency models: strobe+address shifted through a LAT-deep pipe
   logic [AW:0] pipe_a [0:LAT_A-1];
   logic [AW:0] pipe_b [0:LAT_B-1];

   always @(posedge clk) begin
      pipe_a[0] <= {flash_ready, flash_address};
      for (int i = 1; i < int'(LAT_A); i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= {flash_ready_b, flash_address_b};
   end

   assign flash_data_in   = pipe_a[LAT_A-1][AW] ? (pipe_a[LAT_A-1][AW-1:0] ^ 16'hBEFF) : 16'hDEAD;
   assign flash_data_in_b = pipe_b[LAT_B-1][AW] ? (pipe_b[LAT_B-1][AW-1:0] ^ 16'hBEFF) : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " gnt0"}, 32'(gnt0), 32'd0);
      check({tag, " gnt1"}, 32'(gnt1), 32'd0);
      check({tag, " rvalid0"}, 32'(rvalid0), 32'd0);
      check({tag, " rvalid1"}, 32'(rvalid1), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " flash_ready"}, 32'(flash_ready), 32'd0);
      check({tag, " rdata"}, 32'(rdata), 32'd0);
      check({tag, " flash_address"}, 32'(flash_address), 32'd0);
   endtask

   initial begin
      int seq [0:2];
      int got;
      int overlap;
      int cnt_gnt1;
      int cnt_strobe;
      int cnt_rv0;
      int cnt_rv1;

      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      req0_b = 1'b0; req1_b = 1'b0; addr0_b = '0; addr1_b = '0;
      tick(); tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // 1) single port 0 read
      req0 = 1'b1; addr0 = 16'h0010;
      tick();
      check("t1 gnt0", 32'(gnt0), 32'd1);
      check("t1 gnt1", 32'(gnt1), 32'd0);
      check("t1 strobe", 32'(flash_ready), 32'd1);
      check("t1 addr", 32'(flash_address), 32'h0010);
      check("t1 busy", 32'(busy), 32'd1);
      req0 = 1'b0;
      repeat (11) tick();
      check("t1 rvalid0 early", 32'(rvalid0), 32'd0);
      check("t1 busy wait", 32'(busy), 32'd1);
      tick();
      check("t1 rvalid0", 32'(rvalid0), 32'd1);
      check("t1 rdata", 32'(rdata), 32'hBEEF);
      tick();
      check("t1 rvalid0 width", 32'(rvalid0), 32'd0);
      check("t1 busy end", 32'(busy), 32'd0);
      check("t1 rdata hold", 32'(rdata), 32'hBEEF);
      check("t1 addr hold", 32'(flash_address), 32'h0010);

      // 2) simultaneous requests after reset: port 0 first, port 1 fourteen cycles later
      rst = 1'b1;
      tick();
      check_idle_outputs("t2 reset");
      rst = 1'b0;
      tick();
      req0 = 1'b1; addr0 = 16'h0001;
      req1 = 1'b1; addr1 = 16'h0100;
      tick();
      check("t2 gnt0", 32'(gnt0), 32'd1);
      check("t2 gnt1 low", 32'(gnt1), 32'd0);
      check("t2 addr0", 32'(flash_address), 32'h0001);
      repeat (12) tick();
      check("t2 rvalid0", 32'(rvalid0), 32'd1);
      check("t2 rvalid1 low", 32'(rvalid1), 32'd0);
      check("t2 rdata0", 32'(rdata), 32'hBEFE);
      tick();
      check("t2 idle busy", 32'(busy), 32'd0);
      check("t2 idle strobe", 32'(flash_ready), 32'd0);
      tick();
      check("t2 gnt1", 32'(gnt1), 32'd1);
      check("t2 gnt0 low", 32'(gnt0), 32'd0);
      check("t2 strobe1", 32'(flash_ready), 32'd1);
      check("t2 addr1", 32'(flash_address), 32'h0100);
      req0 = 1'b0; req1 = 1'b0;
      repeat (12) tick();
      check("t2 rvalid1", 32'(rvalid1), 32'd1);
      check("t2 rvalid0 low", 32'(rvalid0), 32'd0);
      check("t2 rdata1", 32'(rdata), 32'hBFFF);
      tick();
      check("t2 busy end", 32'(busy), 32'd0);

      // 3) req0 held, req1 raised during port 0 WAIT: order 0,1,0,1
      req0 = 1'b1; addr0 = 16'h0002;
      tick();
      check("t3 first gnt0", 32'(gnt0), 32'd1);
      repeat (3) tick();
      req1 = 1'b1; addr1 = 16'h0200;
      seq[0] = -1; seq[1] = -1; seq[2] = -1;
      got = 0; overlap = 0;
      for (int c = 0; c < 60 && got < 3; c++) begin
         tick();
         if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) overlap++;
         if (gnt0 || gnt1) begin
            seq[got] = gnt1 ? 1 : 0;
            got++;
            if (got == 3) begin
               req0 = 1'b0; req1 = 1'b0;
            end
         end
      end
      check("t3 grant count", 32'(got), 32'd3);
      check("t3 order second", 32'(seq[0]), 32'd1);
      check("t3 order third", 32'(seq[1]), 32'd0);
      check("t3 order fourth", 32'(seq[2]), 32'd1);
      check("t3 overlap", 32'(overlap), 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      for (int c = 0; c < 20 && busy; c++) tick();
      check("t3 drained", 32'(busy), 32'd0);

      // 4) short req1 pulse while busy is ignored
      req0 = 1'b1; addr0 = 16'h0020;
      tick();
      check("t4 gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      repeat (2) tick();
      req1 = 1'b1; addr1 = 16'h0300;
      tick();
      req1 = 1'b0;
      cnt_gnt1 = 0; cnt_strobe = 0; cnt_rv0 = 0;
      for (int c = 0; c < 13; c++) begin
         tick();
         if (gnt1) cnt_gnt1++;
         if (flash_ready) cnt_strobe++;
         if (rvalid0) cnt_rv0++;
      end
      check("t4 no gnt1", 32'(cnt_gnt1), 32'd0);
      check("t4 no strobe", 32'(cnt_strobe), 32'd0);
      check("t4 rvalid0 once", 32'(cnt_rv0), 32'd1);
      check("t4 busy end", 32'(busy), 32'd0);
      check("t4 rdata", 32'(rdata), 32'hBEDF);

      // 5) reset at cnt=5 during a port 1 read
      req1 = 1'b1; addr1 = 16'h0555;
      tick();
      check("t5 gnt1", 32'(gnt1), 32'd1);
      req1 = 1'b0;
      repeat (5) tick();
      check("t5 busy before rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_idle_outputs("t5 async rst");
      tick(); tick();
      rst = 1'b0;
      cnt_rv1 = 0; cnt_strobe = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (rvalid1) cnt_rv1++;
         if (flash_ready) cnt_strobe++;
      end
      check("t5 no rvalid1", 32'(cnt_rv1), 32'd0);
      check("t5 no strobe", 32'(cnt_strobe), 32'd0);
      req0 = 1'b1; addr0 = 16'h0042;
      tick();
      check("t5 gnt0 after rst", 32'(gnt0), 32'd1);
      check("t5 addr after rst", 32'(flash_address), 32'h0042);
      req0 = 1'b0;
      repeat (12) tick();
      check("t5 rvalid0", 32'(rvalid0), 32'd1);
      check("t5 rdata", 32'(rdata), 32'hBEBD);

      // 6) RD_LATENCY=1 instance
      req0_b = 1'b1; addr0_b = 16'h0A0A;
      tick();
      check("t6 gnt0", 32'(gnt0_b), 32'd1);
      check("t6 strobe", 32'(flash_ready_b), 32'd1);
      check("t6 addr", 32'(flash_address_b), 32'h0A0A);
      req0_b = 1'b0;
      tick();
      check("t6 rvalid0 early", 32'(rvalid0_b), 32'd0);
      check("t6 busy", 32'(busy_b), 32'd1);
      tick();
      check("t6 rvalid0", 32'(rvalid0_b), 32'd1);
      check("t6 rdata", 32'(rdata_b), 32'hB4F5);
      tick();
      check("t6 busy end", 32'(busy_b), 32'd0);
      check("t6 rvalid1", 32'(rvalid1_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
